mux_rr_nw: RTL and testbench

Parametrised N-channel, W-bit registered multiplexer with valid/ready handshaking on every input and on the output. It generalises the team's 4:1 single-bit muxes in three ways: any channel count, any data width, and a selectable mode that is either externally steered (fixed select) or round-robin arbitrated. It sits between several producers and one consumer, for example as a front-end for a shared serialiser or a bus master.

---
 rtl/mux_rr_nw.sv | 99 +++++++++
 tb/tb_mux_rr_nw.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_nw.sv
// mux_rr_nw: N-channel, W-bit registered multiplexer with valid/ready on
// every input and on the output. The mode input picks between an externally
// steered channel (mode=0, sel) and round-robin arbitration (mode=1).
// One output register (out_data/out_ch/out_valid) plus the pointer `last`,
// which records the most recent grant in either mode.

module mux_rr_nw #(
  parameter int N = 4,
  parameter int W = 8,
  localparam int SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           mode,
  input  logic [SW-1:0]  sel,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_ch,
  output logic           out_valid,
  input  logic           out_ready
);

  logic [SW-1:0] last;
  logic [SW-1:0] grant;
  logic          gnt_valid;
  logic [W-1:0]  gnt_data;
  logic          load;
  logic          take;
  logic [SW:0]   rr_pick;

  // The search starts just after `last` and wraps modulo N, so `last` itself
  // is considered only after every other channel. Iterating from the far end
  // lets the closest valid channel overwrite earlier candidates without a break.
  function automatic logic [SW:0] rr_search(input logic [SW-1:0] start,
                                            input logic [N-1:0] valid);
    logic [SW:0] res;
    int          c;
    res = '0;
    for (int k = N; k >= 1; k--) begin
      c = int'(start) + k;
      if (c >= N) c = c - N;
      if (valid[c]) res = {1'b1, SW'(c)};
    end
    return res;
  endfunction

  assign load    = !out_valid || out_ready;
  assign rr_pick = rr_search(last, in_valid);

  // Grant selection for the current cycle; sel values past N-1 never grant.
  always_comb begin
    grant     = '0;
    gnt_valid = 1'b0;
    if (mode) begin
      grant     = rr_pick[SW-1:0];
      gnt_valid = rr_pick[SW];
    end else if (int'(sel) < N) begin
      grant     = sel;
      gnt_valid = in_valid[sel];
    end
  end

  // Data of the granted channel.
  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < N; i++) begin
      if (SW'(i) == grant) gnt_data = in_data[i*W +: W];
    end
  end

  assign take = load && gnt_valid;

  // Handshake back to the producers: at most one bit, and never during reset.
  always_comb begin
    in_ready = '0;
    if (!rst && take) in_ready[grant] = 1'b1;
  end

  // Output register and round-robin pointer; an input transfer wins over a
  // plain drain so a simultaneous accept/reload keeps full throughput.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      last      <= SW'(N - 1);
    end else if (take) begin
      out_data  <= gnt_data;
      out_ch    <= grant;
      out_valid <= 1'b1;
      last      <= grant;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_rr_nw.sv
// Testbench for mux_rr_nw: directed scenarios with literal expectations plus
// a randomized run checked against a behavioural reference model.

module tb_mux_rr_nw;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode;
  logic [1:0]  sel;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_valid;
  logic        out_ready;

  logic        mode3;
  logic [1:0]  sel3;
  logic [23:0] in_data3;
  logic [2:0]  in_valid3;
  logic [2:0]  in_ready3;
  logic [7:0]  out_data3;
  logic [1:0]  out_ch3;
  logic        out_valid3;
  logic        out_ready3;

  int errors = 0;
  int checks = 0;

  // reference model state
  bit         m_valid;
  logic [7:0] m_data;
  int         m_ch;
  int         m_last;

  always #5 clk = ~clk;

  mux_rr_nw #(.N(4), .W(8)) dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
  );

  mux_rr_nw #(.N(3), .W(8)) dut3 (
    .clk(clk), .rst(rst), .mode(mode3), .sel(sel3), .in_data(in_data3),
    .in_valid(in_valid3), .in_ready(in_ready3), .out_data(out_data3),
    .out_ch(out_ch3), .out_valid(out_valid3), .out_ready(out_ready3)
  );

  // Which channel the rules pick, or -1 for none.
  function automatic int ref_grant(bit md, int s, logic [3:0] v, int last);
    if (!md) return (s < 4 && v[s]) ? s : -1;
    for (int k = 1; k <= 4; k++) begin
      if (v[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready();
    int g;
    if (rst) return 4'b0;
    if (m_valid && !out_ready) return 4'b0;
    g = ref_grant(mode, int'(sel), in_valid, m_last);
    return (g >= 0) ? (4'b1 << g) : 4'b0;
  endfunction

  function automatic void model_reset();
    m_valid = 0; m_data = 8'h00; m_ch = 0; m_last = 3;
  endfunction

  // Advance one clock edge, updating the model from the inputs at the edge.
  task automatic tick();
    int g;
    bit ld;
    ld = !m_valid || out_ready;
    g  = ref_grant(mode, int'(sel), in_valid, m_last);
    @(posedge clk);
    if (rst) model_reset();
    else if (ld && g >= 0) begin
      m_valid = 1; m_data = in_data[g*8 +: 8]; m_ch = g; m_last = g;
    end else if (m_valid && out_ready) m_valid = 0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1; mode = 1; sel = 0; in_valid = 4'hF; out_ready = 1;
    in_data = {8'h43, 8'h32, 8'h21, 8'h10};
    mode3 = 0; sel3 = 0; in_valid3 = 3'b0; out_ready3 = 1;
    in_data3 = {8'hC2, 8'hB1, 8'hA0};
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", out_data); end
    checks++; if (out_ch !== 2'd0) begin errors++; $display("FAIL reset_ch: got %0d want 0", out_ch); end
    checks++; if (in_ready !== 4'b0) begin errors++; $display("FAIL reset_ready: got %b want 0000", in_ready); end
    rst = 0;
    #1;
    checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL reset_first_ready: got %b want 0001", in_ready); end
    tick();
    checks++; if (out_ch !== 2'd0 || out_valid !== 1'b1 || out_data !== 8'h10) begin
      errors++; $display("FAIL reset_first_grant: got ch=%0d v=%b d=%h want ch=0 v=1 d=10", out_ch, out_valid, out_data);
    end
  endtask

  task automatic test_fixed_sweep();
    logic [7:0] exp_d;
    mode = 0; in_valid = 4'hF; out_ready = 1;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #1;
      checks++; if (in_ready !== (4'b1 << s)) begin errors++; $display("FAIL fixed_ready%0d: got %b want %b", s, in_ready, 4'b1 << s); end
      tick();
      exp_d = 8'h10 + 8'(8'h11 * s);
      checks++; if (out_data !== exp_d || out_ch !== 2'(s)) begin
        errors++; $display("FAIL fixed_out%0d: got d=%h ch=%0d want d=%h ch=%0d", s, out_data, out_ch, exp_d, s);
      end
    end
  endtask

  task automatic test_sel_oob();
    mode3 = 0; sel3 = 2'd1; in_valid3 = 3'b111; out_ready3 = 1;
    tick();
    checks++; if (out_valid3 !== 1'b1 || out_data3 !== 8'hB1 || out_ch3 !== 2'd1) begin
      errors++; $display("FAIL n3_load: got v=%b d=%h ch=%0d want v=1 d=b1 ch=1", out_valid3, out_data3, out_ch3);
    end
    sel3 = 2'd3;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (in_ready3 !== 3'b0) begin errors++; $display("FAIL n3_oob_ready: got %b want 000", in_ready3); end
      tick();
      checks++; if (out_valid3 !== 1'b0) begin errors++; $display("FAIL n3_oob_valid: got %b want 0", out_valid3); end
    end
  endtask

  task automatic test_rr_fair();
    mode = 1; in_valid = 4'hF; out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++; if (in_ready !== (4'b1 << (i % 4))) begin errors++; $display("FAIL rr_ready%0d: got %b want %b", i, in_ready, 4'b1 << (i % 4)); end
      tick();
      checks++; if (out_ch !== 2'(i % 4) || out_valid !== 1'b1) begin
        errors++; $display("FAIL rr_seq%0d: got ch=%0d v=%b want ch=%0d v=1", i, out_ch, out_valid, i % 4);
      end
    end
  endtask

  task automatic test_rr_sparse();
    int exp_a[4] = '{1, 3, 1, 3};
    mode = 1; in_valid = 4'b1010; out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (out_ch !== 2'(exp_a[i])) begin errors++; $display("FAIL sparse%0d: got ch=%0d want %0d", i, out_ch, exp_a[i]); end
    end
    in_valid = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (out_ch !== 2'd3 || out_valid !== 1'b1) begin errors++; $display("FAIL single%0d: got ch=%0d v=%b want ch=3 v=1", i, out_ch, out_valid); end
    end
  endtask

  task automatic test_backpressure();
    mode = 0; sel = 2'd1; in_valid = 4'hF; out_ready = 1;
    tick();
    out_ready = 0; sel = 2'd2;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (in_ready !== 4'b0) begin errors++; $display("FAIL bp_ready%0d: got %b want 0000", i, in_ready); end
      tick();
      checks++; if (out_data !== 8'h21 || out_ch !== 2'd1 || out_valid !== 1'b1) begin
        errors++; $display("FAIL bp_hold%0d: got d=%h ch=%0d v=%b want d=21 ch=1 v=1", i, out_data, out_ch, out_valid);
      end
    end
    out_ready = 1;
    #1;
    checks++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL bp_release_ready: got %b want 0100", in_ready); end
    tick();
    checks++; if (out_data !== 8'h32 || out_valid !== 1'b1) begin
      errors++; $display("FAIL bp_b2b: got d=%h v=%b want d=32 v=1", out_data, out_valid);
    end
  endtask

  task automatic test_mode_switch();
    mode = 1; in_valid = 4'b0100; out_ready = 1;
    tick();
    checks++; if (out_ch !== 2'd2) begin errors++; $display("FAIL ms_rr: got ch=%0d want 2", out_ch); end
    mode = 0; sel = 2'd0; in_valid = 4'hF;
    tick();
    checks++; if (out_ch !== 2'd0) begin errors++; $display("FAIL ms_fixed: got ch=%0d want 0", out_ch); end
    mode = 1;
    tick();
    checks++; if (out_ch !== 2'd1 || out_data !== 8'h21) begin errors++; $display("FAIL ms_resume: got ch=%0d d=%h want ch=1 d=21", out_ch, out_data); end
    #2 rst = 1;
    model_reset();
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== 8'h00 || in_ready !== 4'b0) begin
      errors++; $display("FAIL ms_reset: got v=%b d=%h rdy=%b want v=0 d=00 rdy=0000", out_valid, out_data, in_ready);
    end
    tick();
    rst = 0;
    #1;
    checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL ms_after_reset: got %b want 0001", in_ready); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) mode = 1'($urandom_range(0, 1));
      sel       = 2'($urandom_range(0, 3));
      in_valid  = 4'($urandom);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      checks++; if (in_ready !== exp_ready()) begin errors++; $display("FAIL rnd_ready%0d: got %b want %b", i, in_ready, exp_ready()); end
      tick();
      checks++; if (out_valid !== m_valid || out_data !== m_data || out_ch !== 2'(m_ch)) begin
        errors++; $display("FAIL rnd_out%0d: got v=%b d=%h ch=%0d want v=%b d=%h ch=%0d",
                           i, out_valid, out_data, out_ch, m_valid, m_data, m_ch);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fixed_sweep();
    test_sel_oob();
    test_rr_fair();
    test_rr_sparse();
    test_backpressure();
    test_mode_switch();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
